// File: rtl/videoproc_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers to the video core.
// Independent AW/W acceptance, single outstanding write and read, byte-strobed commits.
module videoproc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3
);

  localparam int IdxW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef logic [IdxW-1:0] idx_t;

  logic                          aw_q, w_q, bvalid_q, rvalid_q;
  idx_t                          aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [StrbW-1:0]              wstrb_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];

  logic                          aw_hs, w_hs, ar_hs, commit, wr_mapped, rd_mapped;
  idx_t                          wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]              wr_strb;

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ~ARESET & ~aw_q & ~bvalid_q;
  assign S_AXI_WREADY  = ~ARESET & ~w_q & ~bvalid_q;
  assign S_AXI_ARREADY = ~ARESET & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Latched halves take priority; otherwise use the half handshaking this cycle.
  assign wr_idx  = aw_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_q ? wstrb_q : S_AXI_WSTRB;
  assign commit  = (aw_q | aw_hs) & (w_q | w_hs);

  assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_mapped = (wr_idx < idx_t'(4));
  assign rd_mapped = (rd_idx < idx_t'(4));

  always_comb begin
    for (int r = 0; r < 4; r++) regs_d[r] = regs_q[r];
    if (commit && wr_mapped) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wr_strb[b]) regs_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
      for (int r = 0; r < 4; r++) regs_q[r] <= '0;
    end else begin
      aw_q <= commit ? 1'b0 : (aw_q | aw_hs);
      w_q  <= commit ? 1'b0 : (w_q | w_hs);
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RespOkay : RespSlvErr;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      // Reads sample regs_q, so a same-cycle write to the same index returns the old value.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mapped ? regs_q[rd_idx[1:0]] : '0;
        rresp_q  <= rd_mapped ? RespOkay : RespSlvErr;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      for (int r = 0; r < 4; r++) regs_q[r] <= regs_d[r];
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign REG0 = regs_q[0];
  assign REG1 = regs_q[1];
  assign REG2 = regs_q[2];
  assign REG3 = regs_q[3];

endmodule

// File: tb/tb_videoproc_axil_regs.sv
// Directed bench for videoproc_axil_regs: vector table of single transactions plus
// hand-written sequences for handshake ordering, back-pressure, read/write overlap and reset.
module tb_videoproc_axil_regs;

  logic        clk = 1'b0;
  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, reg0, reg1, reg2, reg3;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  videoproc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG0(reg0), .REG1(reg1), .REG2(reg2), .REG3(reg3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // All driving and sampling happens at negedge; handshakes resolve at the posedge between.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic ok);
    logic aw_done, w_done, aw_fire, w_fire;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1'b1;  wvalid = 1'b0;  end
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    ok = bvalid; resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic ok);
    logic fire;
    int   n;
    n = 0; fire = 1'b0;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!fire && n < 50) begin
      fire = arready;
      @(negedge clk); n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    ok = rvalid; d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic        ok;

    vecs[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h1};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'h2};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h3};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 2'b00, 32'h4};
    vecs[8]  = '{1'b1, 6'h20, 32'hDEAD,     4'hF, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[10] = '{1'b1, 6'h04, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 6'h04, 32'h11223344, 4'h5, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};
    vecs[13] = '{1'b1, 6'h08, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h3};
    vecs[15] = '{1'b0, 6'h05, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};

    areset = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'h0);
    check("rst_wready",  {31'b0, wready},  32'h0);
    check("rst_arready", {31'b0, arready}, 32'h0);
    check("rst_bvalid",  {31'b0, bvalid},  32'h0);
    check("rst_rvalid",  {31'b0, rvalid},  32'h0);
    check("rst_rdata",   rdata, 32'h0);
    check("rst_reg0",    reg0,  32'h0);
    areset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", {31'b0, awready}, 32'h1);
    check("post_rst_wready",  {31'b0, wready},  32'h1);
    check("post_rst_arready", {31'b0, arready}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
        check($sformatf("vec%0d_bvalid", i), {31'b0, ok}, 32'h1);
        check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, d, resp, ok);
        check($sformatf("vec%0d_rvalid", i), {31'b0, ok}, 32'h1);
        check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end
    check("tbl_reg0", reg0, 32'h1);
    check("tbl_reg1", reg1, 32'hAA22CC44);
    check("tbl_reg2", reg2, 32'h3);
    check("tbl_reg3", reg3, 32'h4);

    // W three cycles ahead of AW, then B back-pressured for four cycles
    wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1; awaddr = 6'h0C;
    check("wfirst_wready", {31'b0, wready}, 32'h1);
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready_low", {31'b0, wready},  32'h0);
    check("wfirst_no_bvalid",  {31'b0, bvalid},  32'h0);
    check("wfirst_reg3_old",   reg3, 32'h4);
    repeat (2) @(negedge clk);
    awvalid = 1'b1;
    check("wfirst_awready", {31'b0, awready}, 32'h1);
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst_bvalid", {31'b0, bvalid}, 32'h1);
    check("wfirst_reg3",   reg3, 32'hCAFE0001);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bhold%0d_bvalid", k),  {31'b0, bvalid},  32'h1);
      check($sformatf("bhold%0d_bresp", k),   {30'b0, bresp},   32'h0);
      check($sformatf("bhold%0d_awready", k), {31'b0, awready}, 32'h0);
      check($sformatf("bhold%0d_wready", k),  {31'b0, wready},  32'h0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bdone_bvalid",  {31'b0, bvalid},  32'h0);
    check("bdone_awready", {31'b0, awready}, 32'h1);
    check("bdone_wready",  {31'b0, wready},  32'h1);

    // Read and write to the same index in the same cycle
    axi_write(6'h08, 32'h5, 4'hF, resp, ok);
    check("ovl_pre_reg2", reg2, 32'h5);
    awaddr = 6'h08; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("ovl_rvalid", {31'b0, rvalid}, 32'h1);
    check("ovl_rdata",  rdata, 32'h5);
    check("ovl_bvalid", {31'b0, bvalid}, 32'h1);
    check("ovl_reg2",   reg2, 32'h9);
    @(negedge clk);
    check("ovl_rhold_rdata",   rdata, 32'h5);
    check("ovl_rhold_arready", {31'b0, arready}, 32'h0);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    check("ovl_rdone_rvalid",  {31'b0, rvalid},  32'h0);
    check("ovl_rdone_arready", {31'b0, arready}, 32'h1);
    axi_read(6'h08, d, resp, ok);
    check("ovl_readback", d, 32'h9);

    // Reset while BVALID is pending
    awaddr = 6'h00; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("rstmid_bvalid", {31'b0, bvalid}, 32'h1);
    check("rstmid_reg0",   reg0, 32'h7);
    areset = 1'b1;
    @(negedge clk);
    check("rstmid_bvalid_drop", {31'b0, bvalid}, 32'h0);
    check("rstmid_reg0_clr",    reg0, 32'h0);
    check("rstmid_reg1_clr",    reg1, 32'h0);
    areset = 1'b0;
    @(negedge clk);
    axi_read(6'h00, d, resp, ok);
    check("rstmid_readback", d, 32'h0);
    check("rstmid_rresp",    {30'b0, resp}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/videoproc_axil_regs.md
VIDEOPROC_AXIL_REGS -- requirements
Module: videoproc_axil_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width (only 32 supported).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, the byte-address width (16 word slots).
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  ACLK  in  1  single clock; all logic on rising edge.
  ARESET  in  1  reset, synchronous, active-high.
  S_AXI_AWADDR  in  ADDR_WIDTH  write address.
  S_AXI_AWPROT  in  3  ignored.
  S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 each  write-address handshake.
  S_AXI_WDATA  in  32  write data.
  S_AXI_WSTRB  in  4  byte strobes.
  S_AXI_WVALID / S_AXI_WREADY  in / out  1 each  write-data handshake.
  S_AXI_BRESP  out  2  write response.
  S_AXI_BVALID / S_AXI_BREADY  out / in  1 each  write-response handshake.
  S_AXI_ARADDR  in  ADDR_WIDTH  read address.
  S_AXI_ARPROT  in  3  ignored.
  S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 each  read-address handshake.
  S_AXI_RDATA  out  32  read data.
  S_AXI_RRESP  out  2  read response.
  S_AXI_RVALID / S_AXI_RREADY  out / in  1 each  read-data handshake.
  REG0..REG3  out  32 each  current register contents, driven to the video core.

Function
REQ-004 Word index SHALL be ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored; indices 0-3 map to REG0-REG3, indices 4-15 are unmapped.
REQ-005 AWREADY SHALL be high iff no write address is latched and BVALID is low; WREADY likewise for write data; AW and W SHALL be accepted independently in either order or the same cycle.
REQ-006 In the cycle where address and data are both held (latched or handshaking), the write SHALL commit at that clock edge and BVALID SHALL be high the next cycle (latency 1 from the later of AW/W handshake).
REQ-007 Commit SHALL update only bytes whose WSTRB bit is 1; WSTRB=0000 leaves the register unchanged but returns OKAY.
REQ-008 BRESP SHALL be 00 (OKAY) for mapped indices and 10 (SLVERR) for unmapped indices; unmapped writes alter no state.
REQ-009 BVALID SHALL hold with stable BRESP until BREADY; latches clear on the B handshake and AWREADY/WREADY return high the following cycle.
REQ-010 ARREADY SHALL be high iff RVALID is low; on AR handshake RDATA/RRESP SHALL be registered and RVALID high the next cycle (latency 1).
REQ-011 Read of unmapped index SHALL return RDATA=0, RRESP=10; mapped index RRESP=00.
REQ-012 RVALID, RDATA, RRESP SHALL hold stable until RREADY; on R handshake RVALID drops and ARREADY is high the next cycle.
REQ-013 Read and write SHALL proceed concurrently; if a read is accepted in the same cycle a write commits to the same index, RDATA SHALL return the pre-write value.
REQ-014 At most one outstanding write and one outstanding read; no ID, burst or reordering.
REQ-015 REG0..REG3 SHALL reflect the new value the cycle after commit.

Reset
REQ-016 While ARESET is high at a clock edge: REG0-REG3=0, all latches cleared, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, AWREADY=WREADY=ARREADY=0.
REQ-017 Ready outputs SHALL go high the first cycle after ARESET deasserts.
REQ-018 Reset mid-transaction SHALL abandon it without committing; a pending BVALID/RVALID drops the cycle after the reset edge.

Verification
REQ-019 Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all BRESP/RRESP=00, REG0..REG3 match.
REQ-020 REG1=0xAABBCCDD, write 0x11223344 to 0x4 with WSTRB=0101 -> REG1=0xAA22CC44.
REQ-021 W valid 3 cycles before AW, BREADY held low 4 cycles -> commit on AW handshake, BVALID/BRESP stable until BREADY, AWREADY/WREADY low throughout.
REQ-022 Write to 0x20 and read from 0x3C -> BRESP=10, RRESP=10, RDATA=0, REG0..REG3 unchanged.
REQ-023 REG2=0x5, same-cycle read of 0x8 and write 0x9 to 0x8 -> RDATA=0x5, subsequent read 0x9.
REQ-024 Assert ARESET while BVALID pending after writing 0x7 to 0x0 (REG0 committed) -> REG0=0, BVALID=0 next cycle, readback of 0x0 returns 0.
